// File: rtl/up_peri_regbank.sv
// up_peri_regbank: register bank on the up_* bus with version, scratch,
// a loadable counter, W1C interrupts, RW control words and RO status words.
//
// Ports:
//   up_clk, up_rst             clock, synchronous active-high reset
//   up_wreq/waddr/wdata/wack   single-cycle write request and acknowledge
//   up_rreq/raddr/rdata/rack   single-cycle read request, data and ack
//   ctrl_out, ctrl_wstb        exported control words and write strobes
//   stat_in                    status words read back at 0x20+i
//   irq_src, irq               level interrupt sources, combined interrupt
module up_peri_regbank #(
    parameter int          ADDRESS_WIDTH = 14,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter int          CNT_WIDTH     = 32,
    parameter int          NUM_CTRL      = 4,
    parameter int          NUM_STAT      = 4,
    parameter int          NUM_IRQ       = 8
) (
    input  logic                     up_clk,
    input  logic                     up_rst,
    input  logic                     up_wreq,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    output logic [NUM_CTRL*32-1:0]   ctrl_out,
    output logic [NUM_CTRL-1:0]      ctrl_wstb,
    input  logic [NUM_STAT*32-1:0]   stat_in,
    input  logic [NUM_IRQ-1:0]       irq_src,
    output logic                     irq
);

    localparam int AW = ADDRESS_WIDTH;

    localparam logic [AW-1:0] A_VERSION  = AW'(32'h00);
    localparam logic [AW-1:0] A_SCRATCH  = AW'(32'h01);
    localparam logic [AW-1:0] A_CNT      = AW'(32'h02);
    localparam logic [AW-1:0] A_CNT_CTRL = AW'(32'h03);
    localparam logic [AW-1:0] A_IRQ_STS  = AW'(32'h04);
    localparam logic [AW-1:0] A_IRQ_MASK = AW'(32'h05);
    localparam logic [AW-1:0] A_CTRL0    = AW'(32'h10);
    localparam logic [AW-1:0] A_STAT0    = AW'(32'h20);

    logic                   wack_q, wack_d;
    logic                   rack_q, rack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            scratch_q, scratch_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   en_q, en_d;
    logic [NUM_IRQ-1:0]     sts_q, sts_d;
    logic [NUM_IRQ-1:0]     mask_q, mask_d;
    logic                   irq_q, irq_d;
    logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]    wstb_q, wstb_d;

    logic                   wr_scratch;
    logic                   wr_cnt;
    logic                   wr_cnt_ctrl;
    logic                   wr_irq_sts;
    logic                   wr_irq_mask;
    logic [NUM_CTRL-1:0]    wr_ctrl;
    logic [31:0]            rd_val;
    logic [NUM_IRQ-1:0]     sts_clr;

    assign wr_scratch  = up_wreq && (up_waddr == A_SCRATCH);
    assign wr_cnt      = up_wreq && (up_waddr == A_CNT);
    assign wr_cnt_ctrl = up_wreq && (up_waddr == A_CNT_CTRL);
    assign wr_irq_sts  = up_wreq && (up_waddr == A_IRQ_STS);
    assign wr_irq_mask = up_wreq && (up_waddr == A_IRQ_MASK);

    always_comb begin
        wr_ctrl = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            wr_ctrl[i] = up_wreq && (up_waddr == A_CTRL0 + AW'(i));
        end
    end

    // Read mux sees pre-edge register values, so a read racing a write
    // to the same offset returns the old contents.
    always_comb begin
        rd_val = '0;
        if (up_raddr == A_VERSION) begin
            rd_val = VERSION;
        end else if (up_raddr == A_SCRATCH) begin
            rd_val = scratch_q;
        end else if (up_raddr == A_CNT) begin
            rd_val = 32'(cnt_q);
        end else if (up_raddr == A_CNT_CTRL) begin
            rd_val = {31'b0, en_q};
        end else if (up_raddr == A_IRQ_STS) begin
            rd_val = 32'(sts_q);
        end else if (up_raddr == A_IRQ_MASK) begin
            rd_val = 32'(mask_q);
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (up_raddr == A_CTRL0 + AW'(i)) begin
                rd_val = ctrl_q[32*i +: 32];
            end
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (up_raddr == A_STAT0 + AW'(i)) begin
                rd_val = stat_in[32*i +: 32];
            end
        end
    end

    assign sts_clr = wr_irq_sts ? up_wdata[NUM_IRQ-1:0] : '0;

    always_comb begin
        wack_d    = up_wreq;
        rack_d    = up_rreq;
        rdata_d   = up_rreq ? rd_val : rdata_q;
        scratch_d = wr_scratch ? up_wdata : scratch_q;
        en_d      = wr_cnt_ctrl ? up_wdata[0] : en_q;
        mask_d    = wr_irq_mask ? up_wdata[NUM_IRQ-1:0] : mask_q;

        // Clear beats load beats increment; EN is the pre-write value.
        if (wr_cnt_ctrl && up_wdata[1]) begin
            cnt_d = '0;
        end else if (wr_cnt) begin
            cnt_d = up_wdata[CNT_WIDTH-1:0];
        end else if (en_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // A live source re-sets the bit even if it is cleared this cycle.
        sts_d = (sts_q & ~sts_clr) | irq_src;
        irq_d = |(sts_q & mask_q);

        ctrl_d = ctrl_q;
        wstb_d = wr_ctrl;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (wr_ctrl[i]) begin
                ctrl_d[32*i +: 32] = up_wdata;
            end
        end
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            wack_q    <= 1'b0;
            rack_q    <= 1'b0;
            rdata_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b1;
            sts_q     <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            ctrl_q    <= '0;
            wstb_q    <= '0;
        end else begin
            wack_q    <= wack_d;
            rack_q    <= rack_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            sts_q     <= sts_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            ctrl_q    <= ctrl_d;
            wstb_q    <= wstb_d;
        end
    end

    assign up_wack   = wack_q;
    assign up_rack   = rack_q;
    assign up_rdata  = rdata_q;
    assign ctrl_out  = ctrl_q;
    assign ctrl_wstb = wstb_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_up_peri_regbank.sv
// tb_up_peri_regbank: scoreboard bench for up_peri_regbank.
// Directed scenarios followed by random bus traffic against a reference model.
module tb_up_peri_regbank;

    localparam int          AWD = 14;
    localparam int          CW  = 8;
    localparam int          NC  = 4;
    localparam int          NS  = 4;
    localparam int          NI  = 8;
    localparam logic [31:0] VER = 32'h0001_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wreq = 1'b0;
    logic [AWD-1:0]    waddr = '0;
    logic [31:0]       wdata = '0;
    logic              wack;
    logic              rreq = 1'b0;
    logic [AWD-1:0]    raddr = '0;
    logic [31:0]       rdata;
    logic              rack;
    logic [NC*32-1:0]  ctrl_out;
    logic [NC-1:0]     ctrl_wstb;
    logic [NS*32-1:0]  stat_in = '0;
    logic [NI-1:0]     irq_src = '0;
    logic              irq;

    always #5 clk = ~clk;

    up_peri_regbank #(
        .ADDRESS_WIDTH(AWD),
        .VERSION      (VER),
        .CNT_WIDTH    (CW),
        .NUM_CTRL     (NC),
        .NUM_STAT     (NS),
        .NUM_IRQ      (NI)
    ) dut (
        .up_clk   (clk),
        .up_rst   (rst),
        .up_wreq  (wreq),
        .up_waddr (waddr),
        .up_wdata (wdata),
        .up_wack  (wack),
        .up_rreq  (rreq),
        .up_raddr (raddr),
        .up_rdata (rdata),
        .up_rack  (rack),
        .ctrl_out (ctrl_out),
        .ctrl_wstb(ctrl_wstb),
        .stat_in  (stat_in),
        .irq_src  (irq_src),
        .irq      (irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the register map as plain variables.
    logic [31:0] rd_q[$];
    logic [31:0] m_scratch;
    int          m_cnt;
    bit          m_en;
    bit [NI-1:0] m_sts;
    bit [NI-1:0] m_mask;
    logic [31:0] m_ctrl[NC];
    bit          e_wack = 0;
    bit          e_irq = 0;
    bit [NC-1:0] e_wstb = '0;
    int          wa;
    int          ra;

    function automatic logic [31:0] mread(input int a);
        if (a == 0) return VER;
        if (a == 1) return m_scratch;
        if (a == 2) return 32'(m_cnt);
        if (a == 3) return {31'b0, m_en};
        if (a == 4) return 32'(m_sts);
        if (a == 5) return 32'(m_mask);
        if (a >= 16 && a < 16 + NC) return m_ctrl[a-16];
        if (a >= 32 && a < 32 + NS) return stat_in[32*(a-32) +: 32];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_scratch = '0;
            m_cnt     = 0;
            m_en      = 1;
            m_sts     = '0;
            m_mask    = '0;
            for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
            e_wack = 0;
            e_irq  = 0;
            e_wstb = '0;
        end else begin
            ra = int'(raddr);
            wa = int'(waddr);
            if (rreq) rd_q.push_back(mread(ra));
            e_irq  = |(m_sts & m_mask);
            e_wack = wreq;
            e_wstb = '0;
            if (wreq && wa == 3 && wdata[1]) m_cnt = 0;
            else if (wreq && wa == 2) m_cnt = int'(wdata[CW-1:0]);
            else if (m_en) m_cnt = (m_cnt + 1) % (1 << CW);
            for (int n = 0; n < NI; n++) begin
                if (irq_src[n]) m_sts[n] = 1;
                else if (wreq && wa == 4 && wdata[n]) m_sts[n] = 0;
            end
            if (wreq) begin
                if (wa == 1) m_scratch = wdata;
                if (wa == 3) m_en = wdata[0];
                if (wa == 5) m_mask = wdata[NI-1:0];
                if (wa >= 16 && wa < 16 + NC) begin
                    m_ctrl[wa-16] = wdata;
                    e_wstb[wa-16] = 1;
                end
            end
        end
    end

    // Monitor: pops expected reads on up_rack, compares other outputs.
    logic [NC*32-1:0] e_ctrl_v;
    logic [31:0]      e_rd;

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) e_ctrl_v[32*i +: 32] = m_ctrl[i];
        chk("wack", 128'(wack), 128'(e_wack));
        chk("irq", 128'(irq), 128'(e_irq));
        chk("ctrl_wstb", 128'(ctrl_wstb), 128'(e_wstb));
        chk("ctrl_out", 128'(ctrl_out), 128'(e_ctrl_v));
        if (rack === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("rack_unexpected", 128'(rack), 128'(0));
            end else begin
                e_rd = rd_q.pop_front();
                chk("rdata", 128'(rdata), 128'(e_rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AWD-1:0] a, input logic [31:0] d);
        wreq  = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wreq  = 1'b0;
    endtask

    task automatic rd(input logic [AWD-1:0] a);
        rreq  = 1'b1;
        raddr = a;
        tick();
        rreq  = 1'b0;
    endtask

    function automatic logic [AWD-1:0] pick();
        int r;
        r = $urandom_range(0, 17);
        if (r < 6) return AWD'(r);
        if (r < 10) return AWD'(r + 6 + 4);
        if (r < 14) return AWD'(r + 22);
        if (r == 14) return AWD'(6);
        if (r == 15) return AWD'(20);
        if (r == 16) return AWD'(36);
        return AWD'($urandom);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rack"}, 128'(rack), 128'(0));
        chk({tag, "_wack"}, 128'(wack), 128'(0));
        chk({tag, "_rdata"}, 128'(rdata), 128'(0));
        chk({tag, "_irq"}, 128'(irq), 128'(0));
        chk({tag, "_ctrl"}, 128'(ctrl_out), 128'(0));
        chk({tag, "_wstb"}, 128'(ctrl_wstb), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        rd(AWD'(0));
        rd(AWD'(14'h3F));
        wr(AWD'(1), 32'hA5A5_5A5A);
        rd(AWD'(1));

        // Same-cycle write and read of CTRL[2]: read sees the old value.
        wreq  = 1'b1;
        waddr = AWD'(14'h12);
        wdata = 32'h0000_1234;
        rreq  = 1'b1;
        raddr = AWD'(14'h12);
        tick();
        wreq = 1'b0;
        rreq = 1'b0;
        chk("ctrl2_value", 128'(ctrl_out[95:64]), 128'(32'h1234));
        chk("ctrl2_stb", 128'(ctrl_wstb), 128'(4'b0100));
        tick();
        chk("ctrl2_stb_end", 128'(ctrl_wstb), 128'(0));

        // Counter wrap, hold, clear.
        wr(AWD'(2), 32'h0000_00FE);
        tick();
        rd(AWD'(2));
        rd(AWD'(2));
        wr(AWD'(3), 32'h0);
        rd(AWD'(2));
        rd(AWD'(2));
        wr(AWD'(3), 32'h2);
        rd(AWD'(2));
        rd(AWD'(3));
        wr(AWD'(3), 32'h1);

        // Interrupts.
        wr(AWD'(5), 32'h1);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        chk("irq_rise", 128'(irq), 128'(1));
        irq_src = 8'h01;
        wr(AWD'(4), 32'h1);
        irq_src = 8'h00;
        rd(AWD'(4));
        wr(AWD'(4), 32'h1);
        tick();
        chk("irq_fall", 128'(irq), 128'(0));
        rd(AWD'(4));

        // Status words.
        stat_in[127:96] = 32'hCAFE_F00D;
        rd(AWD'(14'h23));
        wr(AWD'(14'h23), 32'h1111_2222);
        chk("stat_wack", 128'(wack), 128'(1));
        rd(AWD'(14'h23));

        // Reset the cycle after a read request.
        wr(AWD'(1), 32'h5555_AAAA);
        rd(AWD'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        // Read request on the same edge as reset never acknowledges.
        rreq  = 1'b1;
        raddr = AWD'(0);
        rst   = 1'b1;
        tick();
        rst  = 1'b0;
        rreq = 1'b0;
        chk("rst_drop_rack", 128'(rack), 128'(0));
        rd(AWD'(3));
        rd(AWD'(1));
        rd(AWD'(2));

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 299) == 0);
            wreq  = 1'($urandom_range(0, 1));
            waddr = pick();
            wdata = $urandom;
            if (waddr == AWD'(3) && $urandom_range(0, 3) != 0) begin
                wdata = 32'h1;
            end
            rreq  = 1'($urandom_range(0, 1));
            raddr = pick();
            irq_src = ($urandom_range(0, 7) == 0) ? NI'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) begin
                stat_in = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end
        rst     = 1'b0;
        wreq    = 1'b0;
        rreq    = 1'b0;
        irq_src = '0;
        repeat (5) tick();
        chk("rd_queue_drain", 128'(rd_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_peri_regbank.md
# up_peri_regbank

Parametrised register-bank peripheral on the up_* register bus. Provides version, scratch, a loadable free-running counter with enable/clear, a sticky W1C interrupt block with mask and combined IRQ output, exported RW control words with write strobes, and RO status words. Sits behind the up_* bus bridge and is the base block that user peripherals instantiate for their control/status plumbing.

## Interface
- ADDRESS_WIDTH, 14, up_* address width; AW = ADDRESS_WIDTH-1
- VERSION, 32'h0001_0000, value returned at VERSION offset
- CNT_WIDTH, 32, counter width, 1..32
- NUM_CTRL, 4, exported RW control words, 1..16
- NUM_STAT, 4, RO status words, 1..16
- NUM_IRQ, 8, interrupt sources, 1..32

- up_clk  in  1  bus clock; all logic on rising edge
- up_rst  in  1  reset, synchronous, active-high
- up_wreq  in  1  write request, single-cycle
- up_waddr  in  AW+1  write word address
- up_wdata  in  32  write data
- up_wack  out  1  write acknowledge
- up_rreq  in  1  read request, single-cycle
- up_raddr  in  AW+1  read word address
- up_rdata  out  32  read data, valid with up_rack
- up_rack  out  1  read acknowledge
- ctrl_out  out  NUM_CTRL*32  control words, word i at [32i+31:32i]
- ctrl_wstb  out  NUM_CTRL  one-cycle pulse per control word written
- stat_in  in  NUM_STAT*32  status words, same packing
- irq_src  in  NUM_IRQ  level interrupt sources, synchronous to up_clk
- irq  out  1  combined masked interrupt

## Operation
- Full-width address decode on word offsets:
  - 0x00 VERSION RO
  - 0x01 SCRATCH RW, reset 0
  - 0x02 CNT RW: read = counter zero-extended to 32; write loads up_wdata[CNT_WIDTH-1:0]
  - 0x03 CNT_CTRL: bit0 EN RW (reset 1); bit1 CLR write-1 pulse, reads 0; other bits read 0
  - 0x04 IRQ_STATUS W1C, bits [NUM_IRQ-1:0]
  - 0x05 IRQ_MASK RW, reset 0, bits [NUM_IRQ-1:0]
  - 0x10+i, i<NUM_CTRL: CTRL[i] RW, reset 0
  - 0x20+i, i<NUM_STAT: STAT[i] RO, returns stat_in word i
- Unimplemented bits read 0. Unmapped or out-of-range offsets read 32'h0.
- Writes to RO or unmapped offsets are ignored but still acknowledged.
- Counter, per cycle, in priority order:
  - CLR written -> 0
  - CNT written -> load
  - EN=1 -> +1, wrapping modulo 2^CNT_WIDTH
  - otherwise hold
- IRQ_STATUS bit n:
  - set when irq_src[n]=1
  - cleared by a write with up_wdata[n]=1
  - set wins over a simultaneous clear
- irq = registered OR of (IRQ_STATUS & IRQ_MASK).
- ctrl_out is driven directly from the CTRL registers.
- ctrl_wstb[i] pulses in the cycle after a write to CTRL[i], coincident with the new ctrl_out value.

## Timing
- Reset values: up_wack=0, up_rack=0, up_rdata=0, irq=0, ctrl_out=0, ctrl_wstb=0; counter=0; EN=1; status and mask 0.
- Write: up_wreq at edge T -> register updated and up_wack=1 after T, for one cycle. Back-to-back writes every cycle are supported.
- Read: up_rreq at edge T -> up_rdata and up_rack=1 after T. up_rdata holds until the next read. Back-to-back reads every cycle are supported.
- Read samples register values before edge T:
  - simultaneous read/write to the same offset returns the old value
  - a CNT read returns the count before T's increment
- STAT is sampled from stat_in at edge T.
- Status bit set at edge T (irq_src high) -> irq high after edge T+1 if masked in. Clearing the last active bit at T -> irq low after T+1.
- Reset asserted mid-transaction: a pending ack is dropped, and all state returns to reset values on that edge.

## Test plan
- Reset, then read 0x00 -> up_rack one cycle later, up_rdata=32'h0001_0000. Read 0x3F -> 0.
- Write SCRATCH 0xA5A5_5A5A, then read -> same value. In the same cycle, write CTRL[2] 0x1234 and read CTRL[2] -> read returns 0. Next cycle ctrl_out word 2=0x1234 and ctrl_wstb=4'b0100 for one cycle.
- Counter (CNT_WIDTH=8):
  - write CNT 0xFE with EN=1 -> reads 2 and 3 cycles later return 0xFF, then 0x00 (wrap)
  - write CNT_CTRL 0x0 -> value holds
  - write CNT_CTRL 0x2 -> counter becomes 0
- Interrupts: mask=0x01, pulse irq_src[0] for one cycle -> irq high two edges later. Write IRQ_STATUS 0x01 while irq_src[0]=1 -> bit stays set. With irq_src low, the same write clears the bit and irq falls.
- Drive stat_in word 3 with 0xCAFE_F00D, read 0x23 -> 0xCAFE_F00D. Write 0x23 -> up_wack asserts, read value unchanged.
- Assert up_rst in the cycle after up_rreq -> up_rack=0 and all outputs at reset values on the next edge.
